// File: rtl/weight_pkg.sv
// Shared definitions for the weight pulse encoder: FSM state encoding and pulse cap.
package weight_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FRAME_RST = 3'd1,
        GAP       = 3'd2,
        FLIP_HI   = 3'd3,
        FLIP_LO   = 3'd4,
        DONE      = 3'd5
    } weight_state_e;

    localparam int MAX_PULSES = 7;
    localparam int KG_W       = 10;

endpackage

// File: rtl/weight_pulse_encoder_if.sv
// Measurement handshake and pulse outputs of the weight pulse encoder.
interface weight_pulse_encoder_if;
    import weight_pkg::*;

    logic            load_valid;
    logic [KG_W-1:0] load_kg;
    logic            load_ready;
    logic            weight_flip;
    logic            weight_flip_reset;
    logic            frame_done;

    modport master (
        output load_valid, load_kg,
        input  load_ready, weight_flip, weight_flip_reset, frame_done
    );

    modport slave (
        input  load_valid, load_kg,
        output load_ready, weight_flip, weight_flip_reset, frame_done
    );

endinterface

// File: rtl/weight_pulse_encoder_phase_timer.sv
// Loadable down-counter timing each encoder phase; zero marks the last cycle of a phase.
module phase_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         zero
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= value;
        end else if (count_reg != '0) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/weight_pulse_encoder.sv
// Converts a cabin load in kg into a framed pulse train, one weight_flip per UNIT_KG.
// Define WEIGHT_ENC_SAT_EN to cap each frame at MAX_PULSES pulses.
module weight_pulse_encoder
    import weight_pkg::*;
#(
    parameter int UNIT_KG    = 100,
    parameter int PULSE_HIGH = 2,
    parameter int PULSE_LOW  = 2,
    parameter int RST_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    weight_pulse_encoder_if.slave bus
);

    localparam int TW = 16;
    localparam logic [TW-1:0]   RST_LOAD  = TW'(RST_CYCLES - 1);
    localparam logic [TW-1:0]   HIGH_LOAD = TW'(PULSE_HIGH - 1);
    localparam logic [TW-1:0]   LOW_LOAD  = TW'(PULSE_LOW - 1);
    localparam logic [KG_W-1:0] UNIT_VAL  = KG_W'(UNIT_KG);

`ifdef WEIGHT_ENC_SAT_EN
    localparam int PCW = 3;
`else
    localparam int PCW = 10;
`endif

    weight_state_e   state_reg, state_next;
    logic [KG_W-1:0] remainder_reg;
    logic [PCW-1:0]  pulse_count_reg;
    logic            weight_flip_reg;
    logic            weight_flip_reset_reg;
    logic            frame_done_reg;

    logic            timer_load;
    logic [TW-1:0]   timer_value;
    logic            timer_zero;
    logic            take_pulse;
    logic            accept;
    logic            pulse_limit;
    logic            can_pulse;

    phase_timer #(.W(TW)) u_phase_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (timer_load),
        .value (timer_value),
        .zero  (timer_zero)
    );

`ifdef WEIGHT_ENC_SAT_EN
    assign pulse_limit = (pulse_count_reg == PCW'(MAX_PULSES));
`else
    // Counter is wide enough for every pulse a 10-bit load can produce.
    assign pulse_limit = (pulse_count_reg == '1);
`endif

    assign accept    = (state_reg == IDLE) && bus.load_valid;
    assign can_pulse = (remainder_reg >= UNIT_VAL) && !pulse_limit;

    always_comb begin
        state_next  = state_reg;
        timer_load  = 1'b0;
        timer_value = '0;
        take_pulse  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.load_valid) begin
                    state_next  = FRAME_RST;
                    timer_load  = 1'b1;
                    timer_value = RST_LOAD;
                end
            end
            FRAME_RST: begin
                if (timer_zero) begin
                    state_next  = GAP;
                    timer_load  = 1'b1;
                    timer_value = LOW_LOAD;
                end
            end
            GAP, FLIP_LO: begin
                if (timer_zero) begin
                    if (can_pulse) begin
                        state_next  = FLIP_HI;
                        timer_load  = 1'b1;
                        timer_value = HIGH_LOAD;
                        take_pulse  = 1'b1;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            FLIP_HI: begin
                if (timer_zero) begin
                    state_next  = FLIP_LO;
                    timer_load  = 1'b1;
                    timer_value = LOW_LOAD;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they mark.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg             <= IDLE;
            remainder_reg         <= '0;
            pulse_count_reg       <= '0;
            weight_flip_reg       <= 1'b0;
            weight_flip_reset_reg <= 1'b0;
            frame_done_reg        <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                remainder_reg   <= bus.load_kg;
                pulse_count_reg <= '0;
            end else if (take_pulse) begin
                remainder_reg   <= remainder_reg - UNIT_VAL;
                pulse_count_reg <= pulse_count_reg + 1'b1;
            end
            weight_flip_reg       <= (state_next == FLIP_HI);
            weight_flip_reset_reg <= (state_next == FRAME_RST);
            frame_done_reg        <= (state_next == DONE);
        end
    end

    assign bus.load_ready        = (state_reg == IDLE);
    assign bus.weight_flip       = weight_flip_reg;
    assign bus.weight_flip_reset = weight_flip_reset_reg;
    assign bus.frame_done        = frame_done_reg;

endmodule

// File: doc/weight_pulse_encoder.md
WEIGHT_PULSE_ENCODER -- requirements
Module: weight_pulse_encoder

Interface
REQ-001 SHALL have parameter UNIT_KG, default 100, kg represented by one weight_flip pulse (1..1023).
REQ-002 SHALL have parameter PULSE_HIGH, default 2, cycles weight_flip is high per pulse (>=1).
REQ-003 SHALL have parameter PULSE_LOW, default 2, cycles low after each pulse and after the frame reset (>=1).
REQ-004 SHALL have parameter RST_CYCLES, default 2, cycles weight_flip_reset is high per frame (>=1).
REQ-005 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port load_valid, input, 1, load_kg is valid.
REQ-008 SHALL have port load_kg, input, 10, measured cabin load in kg.
REQ-009 SHALL have port load_ready, output, 1, encoder can accept a measurement.
REQ-010 SHALL have port weight_flip, output, 1, registered pulse train, one pulse per UNIT_KG.
REQ-011 SHALL have port weight_flip_reset, output, 1, registered frame-start pulse that clears the downstream counter.
REQ-012 SHALL have port frame_done, output, 1, one-cycle strobe at frame end.

Function
REQ-013 SHALL implement FSM states IDLE, FRAME_RST, GAP, FLIP_HI, FLIP_LO, DONE.
REQ-014 SHALL drive load_ready high only in IDLE; a transfer occurs when load_valid and load_ready are both high on a clk edge (cycle 0).
REQ-015 SHALL capture load_kg into a 10-bit remainder register on transfer; load_kg SHALL not be sampled again until the next transfer.
REQ-016 SHALL enter FRAME_RST in cycle 1, holding weight_flip_reset high for exactly RST_CYCLES cycles, then enter GAP for PULSE_LOW cycles.
REQ-017 SHALL, at GAP or FLIP_LO end, enter FLIP_HI if remainder >= UNIT_KG and the pulse limit is not reached; otherwise enter DONE.
REQ-018 SHALL subtract UNIT_KG from the remainder on FLIP_HI entry, with no divider; the pulse count equals floor(load_kg/UNIT_KG), subject to REQ-027.
REQ-019 SHALL hold weight_flip high for exactly PULSE_HIGH cycles in FLIP_HI, then low for PULSE_LOW cycles in FLIP_LO.
REQ-020 SHALL assert frame_done for exactly one cycle in DONE, then return to IDLE.
REQ-021 SHALL never assert weight_flip and weight_flip_reset in the same cycle.
REQ-022 SHALL ignore load_valid outside IDLE, with no queuing.
REQ-023 SHALL, for load_kg < UNIT_KG, emit the reset pulse and gap, zero flips, then frame_done.

Reset
REQ-024 SHALL, while rst_n is low, immediately force the state to IDLE and clear weight_flip, weight_flip_reset, frame_done, the remainder, the pulse counter and the phase timer to 0.
REQ-025 SHALL drive load_ready high out of reset, including after a reset in mid-frame; any partial frame is abandoned.

Configuration
REQ-026 SHALL use macro WEIGHT_ENC_SAT_EN to select pulse saturation.
REQ-027 SHALL, with WEIGHT_ENC_SAT_EN defined, cap pulses per frame at MAX_PULSES (7), using a 3-bit pulse counter.
REQ-028 SHALL, without WEIGHT_ENC_SAT_EN, emit every pulse up to floor(1023/UNIT_KG), using a 10-bit pulse counter.

Structure
REQ-029 SHALL take the FSM state enum and MAX_PULSES from shared package weight_pkg.
REQ-030 SHALL implement phase durations in one sub-module, phase_timer, a loadable down-counter with a zero flag.

Verification (UNIT_KG=100, PULSE_HIGH=2, PULSE_LOW=2, RST_CYCLES=2)
REQ-031 SHALL cover: load_kg=350 accepted at cycle 0 -> reset high cycles 1-2; flips high at cycles 5-6, 9-10 and 13-14; frame_done at cycle 17; load_ready high at cycle 18.
REQ-032 SHALL cover: load_kg=99 -> reset high cycles 1-2, no flips, frame_done at cycle 5; load_kg=100 -> exactly 1 flip.
REQ-033 SHALL cover: load_kg=1000 -> 7 flips with WEIGHT_ENC_SAT_EN defined, 10 flips without it.
REQ-034 SHALL cover: rst_n low at cycle 6 during the first flip -> all outputs 0 and load_ready 1 in the same cycle; a new load_kg=200 after release gives 2 flips.
REQ-035 SHALL cover: load_valid held high with changing load_kg during a frame -> no effect on the frame; the next transfer occurs at the first IDLE cycle.
